uart_mirror_fifo: RTL and testbench

Parametrised UART echo block placed between the UART_Rx/UART_Tx modules and the user logic. When mirroring, every byte the Rx module receives is captured into an internal FIFO and replayed through the Tx module. Bytes arriving while the Tx module is busy are buffered rather than lost. In BYPASS mode the block is a transparent passive bridge. A TAP mode echoes bytes and also strobes each captured byte to the user side.

---
 rtl/uart_mirror_fifo_pkg.sv | 32 +++
 rtl/uart_mirror_fifo_if.sv | 39 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_mirror_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_mirror_fifo.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mirror_fifo_pkg.sv
// Shared encodings for the UART mirror block: operating modes and the two FSM state sets.
package uart_mirror_fifo_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_MIRROR = 2'd1,
        MODE_TAP    = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        CIDLE,
        CACK,
        CWAIT
    } cap_state_e;

    typedef enum logic [1:0] {
        TIDLE,
        TSEND,
        TWAITHI,
        TWAITLO
    } rep_state_e;

    // The reserved encoding behaves as MIRROR.
    function automatic mode_e decode_mode(logic [1:0] raw);
        case (raw)
            2'd0:    return MODE_BYPASS;
            2'd2:    return MODE_TAP;
            default: return MODE_MIRROR;
        endcase
    endfunction

endpackage

// File: rtl/uart_mirror_fifo_if.sv
// Bundles the user-side, UART-side and status signals of the mirror block.
interface uart_mirror_fifo_if #(
    parameter int unsigned C_UART_DATA_WIDTH = 8,
    parameter int unsigned C_LEVEL_WIDTH     = 5
);
    logic [1:0]                   mode;
    logic                         clrOvf;
    logic                         rxValid;
    logic [C_UART_DATA_WIDTH-1:0] rxData;
    logic                         rxErr;
    logic                         rxAck;
    logic                         txBusy;
    logic                         txErr;
    logic                         txSend;
    logic [C_UART_DATA_WIDTH-1:0] txData;
    logic                         valid;
    logic [C_UART_DATA_WIDTH-1:0] dataIn;
    logic                         errRx;
    logic                         ack;
    logic                         busy;
    logic                         errTx;
    logic                         send;
    logic [C_UART_DATA_WIDTH-1:0] dataOut;
    logic [C_LEVEL_WIDTH-1:0]     fifoLevel;
    logic                         overflow;
    logic [1:0]                   modeActive;

    modport slave (
        input  mode, clrOvf, rxAck, txSend, txData, valid, dataIn, errRx, busy, errTx,
        output rxValid, rxData, rxErr, txBusy, txErr, ack, send, dataOut, fifoLevel,
        overflow, modeActive
    );

    modport master (
        output mode, clrOvf, rxAck, txSend, txData, valid, dataIn, errRx, busy, errTx,
        input  rxValid, rxData, rxErr, txBusy, txErr, ack, send, dataOut, fifoLevel,
        overflow, modeActive
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; full/empty come from the registered level.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned LvlW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LvlW-1:0]  level
);
    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [LvlW-1:0]  level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LvlW'(Depth));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (!do_push && do_pop) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_mirror_fifo.sv
// UART echo bridge: captures Rx bytes into a FIFO and replays them through Tx,
// or passes everything straight through in BYPASS.
module uart_mirror_fifo
    import uart_mirror_fifo_pkg::*;
#(
    parameter int unsigned C_UART_DATA_WIDTH = 8,
    parameter int unsigned C_FIFO_DEPTH      = 16,
    parameter int unsigned C_BUSY_TIMEOUT    = 15
) (
    input logic               clk,
    input logic               rstb,
    uart_mirror_fifo_if.slave bus
);
    localparam int unsigned LvlW = $clog2(C_FIFO_DEPTH) + 1;
    localparam int unsigned CntW = (C_BUSY_TIMEOUT > 1) ? $clog2(C_BUSY_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(C_BUSY_TIMEOUT - 1);

    mode_e                        mode_q, mode_d;
    cap_state_e                   cap_q, cap_d;
    rep_state_e                   rep_q, rep_d;
    logic [C_UART_DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic                         overflow_q, overflow_d;
    logic                         tap_q, tap_d;

    logic                         mirroring;
    logic                         mode_load;
    logic                         fifo_push, fifo_pop, fifo_flush;
    logic                         fifo_full, fifo_empty;
    logic [C_UART_DATA_WIDTH-1:0] fifo_head;
    logic [LvlW-1:0]              fifo_level;
    logic                         drop;
    logic                         ack_fsm, send_fsm;

    sync_fifo #(
        .Width (C_UART_DATA_WIDTH),
        .Depth (C_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (bus.dataIn),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign mirroring = (mode_q != MODE_BYPASS);

    // Mode only changes between transfers; entering BYPASS discards queued bytes.
    always_comb begin
        mode_load  = (cap_q == CIDLE) && (rep_q == TIDLE);
        mode_d     = mode_load ? decode_mode(bus.mode) : mode_q;
        fifo_flush = mode_load && (mode_d == MODE_BYPASS) && mirroring;
    end

    always_comb begin
        cap_d     = cap_q;
        ack_fsm   = 1'b0;
        fifo_push = 1'b0;
        drop      = 1'b0;
        unique case (cap_q)
            CIDLE: if (bus.valid && mirroring) cap_d = CACK;
            CACK: begin
                ack_fsm = 1'b1;
                cap_d   = CWAIT;
                if (!bus.errRx) begin
                    if (fifo_full) drop = 1'b1;
                    else           fifo_push = 1'b1;
                end
            end
            CWAIT: if (!bus.valid) cap_d = CIDLE;
            default: cap_d = CIDLE;
        endcase
        overflow_d = drop ? 1'b1 : (bus.clrOvf ? 1'b0 : overflow_q);
        tap_d      = fifo_push && (mode_q == MODE_TAP);
    end

    always_comb begin
        rep_d      = rep_q;
        send_fsm   = 1'b0;
        fifo_pop   = 1'b0;
        data_out_d = data_out_q;
        cnt_d      = cnt_q;
        unique case (rep_q)
            TIDLE: begin
                if (mirroring && !fifo_empty && !bus.busy) begin
                    rep_d      = TSEND;
                    fifo_pop   = 1'b1;
                    data_out_d = fifo_head;
                end
            end
            TSEND: begin
                send_fsm = 1'b1;
                cnt_d    = '0;
                rep_d    = TWAITHI;
            end
            TWAITHI: begin
                // A Tx that never acknowledges still releases the replay path.
                if (bus.busy)              rep_d = TWAITLO;
                else if (cnt_q == CntLast) rep_d = TIDLE;
                else                       cnt_d = cnt_q + 1'b1;
            end
            TWAITLO: if (!bus.busy) rep_d = TIDLE;
            default: rep_d = TIDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mode_q     <= MODE_BYPASS;
            cap_q      <= CIDLE;
            rep_q      <= TIDLE;
            data_out_q <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            tap_q      <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            cap_q      <= cap_d;
            rep_q      <= rep_d;
            data_out_q <= data_out_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            tap_q      <= tap_d;
        end
    end

    always_comb begin
        bus.rxData     = bus.dataIn;
        bus.rxErr      = bus.errRx;
        bus.fifoLevel  = fifo_level;
        bus.overflow   = overflow_q;
        bus.modeActive = mode_q;
        if (!mirroring) begin
            bus.ack     = bus.rxAck;
            bus.send    = bus.txSend;
            bus.dataOut = bus.txData;
            bus.txBusy  = bus.busy;
            bus.txErr   = bus.errTx;
            bus.rxValid = bus.valid;
        end else begin
            bus.ack     = ack_fsm;
            bus.send    = send_fsm;
            bus.dataOut = data_out_q;
            bus.txBusy  = 1'b1;
            bus.txErr   = 1'b0;
            bus.rxValid = (mode_q == MODE_TAP) && tap_q;
        end
    end

endmodule

// File: tb/tb_uart_mirror_fifo.sv
// Self-checking bench for uart_mirror_fifo: bypass vector table, echo scoreboard,
// and hand-written sequences for overflow, timeout, mode switching and reset.
module tb_uart_mirror_fifo;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 15;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    uart_mirror_fifo_if #(.C_UART_DATA_WIDTH(W), .C_LEVEL_WIDTH(LW)) b ();

    uart_mirror_fifo #(
        .C_UART_DATA_WIDTH (W),
        .C_FIFO_DEPTH      (DEPTH),
        .C_BUSY_TIMEOUT    (TMO)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (b)
    );

    logic       tx_auto    = 1'b0;
    logic       busy_force = 1'b0;
    logic       auto_busy  = 1'b0;
    int         resp_cnt   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    assign b.busy = tx_auto ? auto_busy : busy_force;

    // Tx model: busy rises two cycles after send and stays high for ten cycles.
    always @(posedge clk) begin
        #2;
        if (!tx_auto) begin
            resp_cnt  = 0;
            auto_busy = 1'b0;
        end else begin
            if (resp_cnt == 0) begin
                if (b.send && b.modeActive != 2'd0) resp_cnt = 1;
            end else begin
                resp_cnt++;
            end
            if (resp_cnt >= 13) resp_cnt = 0;
            auto_busy = (resp_cnt >= 3);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rstb && b.send && b.modeActive != 2'd0) obs_q.push_back(b.dataOut);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rx_ack;
        logic       tx_send;
        logic [7:0] tx_data;
        logic       valid;
        logic [7:0] data_in;
        logic       err_rx;
        logic       busy;
        logic       err_tx;
        logic       e_ack;
        logic       e_send;
        logic [7:0] e_dout;
        logic       e_tx_busy;
        logic       e_tx_err;
        logic       e_rx_valid;
        logic [7:0] e_rx_data;
        logic       e_rx_err;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic feed(input logic [7:0] d, input logic e);
        b.valid  = 1'b1;
        b.dataIn = d;
        b.errRx  = e;
        cyc();
        cyc();
        b.valid = 1'b0;
        b.errRx = 1'b0;
        cyc();
    endtask

    task automatic drain_check();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check("echo_byte", obs_q.pop_front(), exp_q.pop_front());
        end
        check("echo_leftover", obs_q.size() + exp_q.size(), 0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int gap;
        b.mode = 2'd0; b.clrOvf = 1'b0; b.rxAck = 1'b0; b.txSend = 1'b0; b.txData = '0;
        b.valid = 1'b0; b.dataIn = '0; b.errRx = 1'b0; b.errTx = 1'b0;
        #3;
        check("rst_ack", b.ack, 0);
        check("rst_send", b.send, 0);
        check("rst_dout", b.dataOut, 0);
        check("rst_ovf", b.overflow, 0);
        check("rst_level", b.fifoLevel, 0);
        check("rst_mode", b.modeActive, 0);
        cyc();
        cyc();
        rstb = 1'b1;
        cyc();

        vecs[0] = '{1'b1, 1'b1, 8'h5A, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0,
                    1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1,
                    1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h81, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1,
                    1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b1};
        for (int i = 0; i < 4; i++) begin
            b.rxAck = vecs[i].rx_ack;  b.txSend = vecs[i].tx_send; b.txData = vecs[i].tx_data;
            b.valid = vecs[i].valid;   b.dataIn = vecs[i].data_in; b.errRx = vecs[i].err_rx;
            busy_force = vecs[i].busy; b.errTx = vecs[i].err_tx;
            #1;
            check("byp_ack", b.ack, vecs[i].e_ack);
            check("byp_send", b.send, vecs[i].e_send);
            check("byp_dout", b.dataOut, vecs[i].e_dout);
            check("byp_txbusy", b.txBusy, vecs[i].e_tx_busy);
            check("byp_txerr", b.txErr, vecs[i].e_tx_err);
            check("byp_rxvalid", b.rxValid, vecs[i].e_rx_valid);
            check("byp_rxdata", b.rxData, vecs[i].e_rx_data);
            check("byp_rxerr", b.rxErr, vecs[i].e_rx_err);
            cyc();
        end
        b.rxAck = 1'b0; b.txSend = 1'b0; b.txData = '0; b.valid = 1'b0; b.dataIn = '0;
        b.errRx = 1'b0; b.errTx = 1'b0; busy_force = 1'b0;
        cyc();

        // Single byte echo in MIRROR
        b.mode  = 2'd1;
        tx_auto = 1'b1;
        cyc();
        #1 check("mir_mode", b.modeActive, 1);
        check("mir_txbusy", b.txBusy, 1);
        exp_q.push_back(8'hA5);
        b.valid = 1'b1; b.dataIn = 8'hA5;
        cyc();
        #1 check("mir_ack_hi", b.ack, 1);
        check("mir_send_lo0", b.send, 0);
        cyc();
        b.valid = 1'b0;
        #1 check("mir_ack_lo", b.ack, 0);
        check("mir_level1", b.fifoLevel, 1);
        check("mir_send_lo1", b.send, 0);
        cyc();
        #1 check("mir_send_hi", b.send, 1);
        check("mir_dout", b.dataOut, 8'hA5);
        check("mir_level0", b.fifoLevel, 0);
        cyc();
        #1 check("mir_send_1cyc", b.send, 0);
        repeat (16) cyc();
        check("mir_level_end", b.fifoLevel, 0);
        drain_check();

        // Overflow with Tx held busy
        tx_auto = 1'b0; busy_force = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            feed(8'(i), 1'b0);
        end
        #1 check("ovf_level", b.fifoLevel, DEPTH);
        check("ovf_set", b.overflow, 1);
        check("ovf_no_send", obs_q.size(), 0);
        busy_force = 1'b0; tx_auto = 1'b1;
        for (int k = 0; k < 800 && obs_q.size() < 16; k++) cyc();
        check("ovf_replay_count", obs_q.size(), 16);
        drain_check();
        repeat (16) cyc();
        check("ovf_level_end", b.fifoLevel, 0);
        check("ovf_sticky", b.overflow, 1);
        b.clrOvf = 1'b1;
        cyc();
        b.clrOvf = 1'b0;
        #1 check("ovf_clear", b.overflow, 0);

        // Rx error: acknowledged but discarded
        tx_auto = 1'b0;
        b.valid = 1'b1; b.dataIn = 8'h3C; b.errRx = 1'b1;
        cyc();
        #1 check("err_ack", b.ack, 1);
        cyc();
        b.valid = 1'b0; b.errRx = 1'b0;
        #1 check("err_ack_lo", b.ack, 0);
        check("err_no_push", b.fifoLevel, 0);
        repeat (5) cyc();
        check("err_no_send", obs_q.size(), 0);
        check("err_no_ovf", b.overflow, 0);

        // Tx never raises busy: timeout, then next byte goes out
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'hB2);
        feed(8'hB1, 1'b0);
        #1 check("to_first_send", b.send, 1);
        feed(8'hB2, 1'b0);
        gap = 3;
        #1;
        while (!b.send && gap < 40) begin
            cyc();
            #1;
            gap++;
        end
        check("timeout_gap", gap, TMO + 2);
        repeat (TMO + 4) cyc();
        drain_check();

        // Mode request held off until replay returns to TIDLE
        exp_q.push_back(8'hC3);
        feed(8'hC3, 1'b0);
        busy_force = 1'b1;
        b.mode = 2'd0;
        cyc();
        #1 check("sw_hold_hi", b.modeActive, 1);
        cyc();
        cyc();
        #1 check("sw_hold_lo", b.modeActive, 1);
        busy_force = 1'b0;
        cyc();
        #1 check("sw_at_idle", b.modeActive, 1);
        cyc();
        #1 check("sw_bypass", b.modeActive, 0);
        drain_check();

        // TAP: strobe to user side, echo, then reset mid-echo
        b.mode = 2'd2;
        cyc();
        #1 check("tap_mode", b.modeActive, 2);
        busy_force = 1'b1;
        exp_q.push_back(8'h81);
        b.valid = 1'b1; b.dataIn = 8'h81;
        cyc();
        #1 check("tap_pre", b.rxValid, 0);
        cyc();
        b.valid = 1'b0;
        #1 check("tap_strobe", b.rxValid, 1);
        check("tap_rxdata", b.rxData, 8'h81);
        check("tap_level1", b.fifoLevel, 1);
        cyc();
        #1 check("tap_strobe_end", b.rxValid, 0);
        feed(8'h82, 1'b0);
        #1 check("tap_level2", b.fifoLevel, 2);
        busy_force = 1'b0;
        cyc();
        #1 check("tap_send", b.send, 1);
        check("tap_dout", b.dataOut, 8'h81);
        check("tap_level_pop", b.fifoLevel, 1);
        rstb = 1'b0;
        #1 check("rst_mid_send", b.send, 0);
        check("rst_mid_level", b.fifoLevel, 0);
        check("rst_mid_ack", b.ack, 0);
        check("rst_mid_mode", b.modeActive, 0);
        cyc();
        rstb = 1'b1;
        cyc();
        cyc();
        drain_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
